math_div_unit: RTL and testbench

- Iterative RV32M divide/remainder unit in the math system, sitting directly upstream of the ALU writeback stage.
- Accepts one DIV/DIVU/REM/REMU micro-op from issue and runs a radix-2 restoring divide over 32 iterations.
- Presents the result as a one-cycle result/rob_id/dest/valid bundle that drives the writeback stage's result inputs directly.
- The writeback stage performs the register-file write and ROB completion.

---
 rtl/math_pkg.sv | 26 ++
 rtl/div_iter_step.sv | 26 ++
 rtl/math_div_unit.sv | 135 +++++++++++++
 tb/tb_math_div_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package math_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  localparam int unsigned DIV_ITERS    = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUO  = 32'h8000_0000;

  // Magnitude of a value, treating it as two's complement only when sgn is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One combinational radix-2 restoring divide step on a {rem, quo} pair.
module div_iter_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // The partial remainder stays below the divisor, so the shifted value never needs bit 32 kept.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/math_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit feeding the writeback stage.
// Optional `DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |rs1|<|rs2| skip CALC.
module math_div_unit
  import math_pkg::*;
#(
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned PRF_W    = 6
) (
  input  logic                cpu_clock_i,
  input  logic                cpu_reset_i,
  input  logic                flush_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  input  logic [1:0]          div_op_i,
  input  logic [31:0]         div_rs1_i,
  input  logic [31:0]         div_rs2_i,
  input  logic [ROB_ID_W-1:0] div_rob_id_i,
  input  logic [PRF_W-1:0]    div_dest_i,
  input  logic                div_wb_valid_i,
  output logic [31:0]         alu_result,
  output logic [ROB_ID_W-1:0] alu_rob_id_o,
  output logic [PRF_W-1:0]    alu_dest_o,
  output logic                alu_wb_valid_o,
  output logic                alu_valid_o
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS);

  div_state_t          state;
  div_op_t             op_q;
  logic [CNT_W-1:0]    count;
  logic [31:0]         rem_q, quo_q, dvsr_q;
  logic [ROB_ID_W-1:0] rob_q;
  logic [PRF_W-1:0]    dest_q;
  logic                wb_q, q_neg, r_neg, zero_q, ovf_q;
  logic [31:0]         rem_nx, quo_nx;

  logic                is_signed, b_zero, ovf_in, early;
  logic [31:0]         a_mag, dividend;
  logic [31:0]         q_fix, r_fix, fix_result;

  div_iter_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign div_ready_o = (state == IDLE);
  assign is_signed   = !div_op_i[0];
  assign a_mag       = mag32(div_rs1_i, is_signed);
  assign b_zero      = (div_rs2_i == '0);
  assign ovf_in      = is_signed && (div_rs1_i == 32'h8000_0000) && (div_rs2_i == '1);
  // A zero divisor runs on raw rs1 so the loop leaves rs1 itself as the remainder.
  assign dividend    = b_zero ? div_rs1_i : a_mag;

`ifdef DIV_EARLY_OUT_EN
  logic [31:0] b_mag;
  assign b_mag = mag32(div_rs2_i, is_signed);
  assign early = b_zero || ovf_in || (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    q_fix = ovf_q ? DIV_OVF_QUO : (zero_q ? quo_q : (q_neg ? -quo_q : quo_q));
    r_fix = ovf_q ? '0          : (zero_q ? rem_q : (r_neg ? -rem_q : rem_q));
    fix_result = op_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      state          <= IDLE;
      op_q           <= DIV;
      count          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvsr_q         <= '0;
      rob_q          <= '0;
      dest_q         <= '0;
      wb_q           <= 1'b0;
      q_neg          <= 1'b0;
      r_neg          <= 1'b0;
      zero_q         <= 1'b0;
      ovf_q          <= 1'b0;
      alu_result     <= '0;
      alu_rob_id_o   <= '0;
      alu_dest_o     <= '0;
      alu_wb_valid_o <= 1'b0;
      alu_valid_o    <= 1'b0;
    end else begin
      alu_valid_o    <= 1'b0;
      alu_wb_valid_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (div_valid_i) begin
            op_q   <= div_op_t'(div_op_i);
            rob_q  <= div_rob_id_i;
            dest_q <= div_dest_i;
            wb_q   <= div_wb_valid_i;
            dvsr_q <= b_zero ? '0 : mag32(div_rs2_i, is_signed);
            q_neg  <= is_signed && (div_rs1_i[31] ^ div_rs2_i[31]);
            r_neg  <= is_signed && div_rs1_i[31];
            zero_q <= b_zero;
            ovf_q  <= ovf_in;
            count  <= '0;
            // Early-out preloads the final loop state: all-ones quotient for /0, zero otherwise.
            rem_q  <= early ? dividend : '0;
            quo_q  <= early ? (b_zero ? DIV_ZERO_QUO : '0) : dividend;
            state  <= early ? FIX : CALC;
          end
          CALC: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            count <= count + 1'b1;
            if (count == CNT_W'(DIV_ITERS - 1)) state <= FIX;
          end
          FIX: begin
            alu_result     <= fix_result;
            alu_rob_id_o   <= rob_q;
            alu_dest_o     <= dest_q;
            alu_valid_o    <= 1'b1;
            alu_wb_valid_o <= wb_q;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_math_div_unit.sv
// Randomised self-checking bench for math_div_unit against an arithmetic reference model.
module tb_math_div_unit;

  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned PRF_W    = 6;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, valid = 1'b0, wb = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [ROB_ID_W-1:0] rob = '0;
  logic [PRF_W-1:0] dest = '0;

  logic ready, v, wbv;
  logic [31:0] res;
  logic [ROB_ID_W-1:0] rob_o;
  logic [PRF_W-1:0] dest_o;

  always #5 clk = ~clk;

  math_div_unit #(.ROB_ID_W(ROB_ID_W), .PRF_W(PRF_W)) dut (
    .cpu_clock_i    (clk),
    .cpu_reset_i    (rst),
    .flush_i        (flush),
    .div_valid_i    (valid),
    .div_ready_o    (ready),
    .div_op_i       (op),
    .div_rs1_i      (rs1),
    .div_rs2_i      (rs2),
    .div_rob_id_i   (rob),
    .div_dest_i     (dest),
    .div_wb_valid_i (wb),
    .alu_result     (res),
    .alu_rob_id_o   (rob_o),
    .alu_dest_o     (dest_o),
    .alu_wb_valid_o (wbv),
    .alu_valid_o    (v)
  );

  int checks = 0, failures = 0;

  // Hand-computed expectation attached to a directed op.
  logic        lit_on = 1'b0;
  logic [31:0] lit_val = '0;
  int          lit_lat = 0;

  function automatic logic [31:0] ref_result(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    logic sgn;
    sgn = !o[0];
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit ref_early(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    bit sgn;
    sgn = !o[0];
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == 0) return 1'b1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return sa < sb;
  endfunction

  // Reference model state
  bit m_busy = 1'b0, m_wb = 1'b0, m_lit_on = 1'b0;
  int m_left = 0, m_acc = 0, m_lat = 0, cyc = 0;
  logic [31:0] m_res = '0, m_lit = '0;
  logic [ROB_ID_W-1:0] m_rob = '0;
  logic [PRF_W-1:0] m_dest = '0;
  bit e_valid = 1'b0, e_wb = 1'b0, e_lit_on = 1'b0;
  logic [31:0] e_res = '0, e_lit = '0;
  logic [ROB_ID_W-1:0] e_rob = '0;
  logic [PRF_W-1:0] e_dest = '0;
  int e_lat_exp = 0, e_lat_obs = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; e_valid = 0; e_wb = 0; e_lit_on = 0;
      e_res = '0; e_rob = '0; e_dest = '0;
    end else begin
      e_valid = 0; e_wb = 0; e_lit_on = 0;
      if (flush) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; e_valid = 1; e_wb = m_wb; e_res = m_res;
          e_rob = m_rob; e_dest = m_dest; e_lit_on = m_lit_on; e_lit = m_lit;
          e_lat_exp = m_lat; e_lat_obs = cyc - m_acc;
        end
      end else if (valid) begin
        m_busy = 1; m_res = ref_result(op, rs1, rs2);
        m_rob = rob; m_dest = dest; m_wb = wb;
        m_left = (EARLY && ref_early(op, rs1, rs2)) ? 1 : 33;
        m_acc = cyc; m_lit_on = lit_on; m_lit = lit_val; m_lat = lit_lat;
      end
      cyc++;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("ready", 32'(ready), 32'(!m_busy));
    check("valid", 32'(v), 32'(e_valid));
    check("wb_valid", 32'(wbv), 32'(e_wb));
    check("result", res, e_res);
    check("rob_id", 32'(rob_o), 32'(e_rob));
    check("dest", 32'(dest_o), 32'(e_dest));
    if (e_valid && e_lit_on) begin
      check("lit_result", res, e_lit);
      check("latency", 32'(e_lat_obs), 32'(e_lat_exp));
    end
  end

  task automatic wait_result();
    int n = 0;
    while (!v && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_op(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [ROB_ID_W-1:0] r,
                       logic [PRF_W-1:0] d, logic w, logic [31:0] lit, bit early_case);
    int n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    valid = 1; op = o; rs1 = a; rs2 = b; rob = r; dest = d; wb = w;
    lit_on = 1; lit_val = lit; lit_lat = (EARLY && early_case) ? 1 : 33;
    @(posedge clk); #1;
    valid = 0; lit_on = 0;
    wait_result();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;

    do_op(OP_DIVU, 100, 7, 5'd1, 6'd10, 1'b1, 32'd14, 1'b0);
    do_op(OP_REMU, 100, 7, 5'd2, 6'd11, 1'b1, 32'd2, 1'b0);
    do_op(OP_DIV, 32'hFFFF_FF9C, 7, 5'd3, 6'd12, 1'b1, 32'hFFFF_FFF2, 1'b0);
    do_op(OP_REM, 32'hFFFF_FF9C, 7, 5'd4, 6'd13, 1'b1, 32'hFFFF_FFFE, 1'b0);
    do_op(OP_DIV, 100, 32'hFFFF_FFF9, 5'd5, 6'd14, 1'b1, 32'hFFFF_FFF2, 1'b0);
    do_op(OP_DIV, 5, 0, 5'd6, 6'd15, 1'b1, 32'hFFFF_FFFF, 1'b1);
    do_op(OP_DIVU, 5, 0, 5'd7, 6'd16, 1'b1, 32'hFFFF_FFFF, 1'b1);
    do_op(OP_REMU, 5, 0, 5'd8, 6'd17, 1'b1, 32'd5, 1'b1);
    do_op(OP_REM, 32'hFFFF_FFFB, 0, 5'd9, 6'd18, 1'b1, 32'hFFFF_FFFB, 1'b1);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 6'd19, 1'b1, 32'h8000_0000, 1'b1);
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 6'd20, 1'b1, 32'h0, 1'b1);
    do_op(OP_DIVU, 9, 3, 5'd12, 6'd21, 1'b0, 32'd3, 1'b0);
    do_op(OP_DIVU, 3, 10, 5'd13, 6'd22, 1'b1, 32'd0, 1'b1);
    do_op(OP_REM, 32'hFFFF_FFFD, 10, 5'd14, 6'd23, 1'b1, 32'hFFFF_FFFD, 1'b1);

    // Flush sampled at E10 kills the op; a fresh op then completes.
    @(posedge clk); #1;
    valid = 1; op = OP_DIVU; rs1 = 1000; rs2 = 3; rob = 5'd20; dest = 6'd30; wb = 1;
    @(posedge clk); #1;
    valid = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    do_op(OP_DIVU, 1000, 3, 5'd21, 6'd31, 1'b1, 32'd333, 1'b0);

    // Valid held high through CALC with a different id: ignored until ready returns.
    @(posedge clk); #1;
    valid = 1; op = OP_DIVU; rs1 = 77; rs2 = 5; rob = 5'd1; dest = 6'd3; wb = 1;
    @(posedge clk); #1;
    rob = 5'd2; dest = 6'd4; rs1 = 50; rs2 = 6;
    wait_result();
    @(posedge clk); #1;
    valid = 0;
    wait_result();

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    valid = 1; op = OP_DIV; rs1 = 12345; rs2 = 7; rob = 5'd9; dest = 6'd9; wb = 1;
    @(posedge clk); #1;
    valid = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (40) @(posedge clk);

    repeat (4000) begin
      @(posedge clk); #1;
      valid = 1'($urandom_range(0, 1));
      op    = 2'($urandom);
      rs1   = pick();
      rs2   = pick();
      rob   = ROB_ID_W'($urandom);
      dest  = PRF_W'($urandom);
      wb    = 1'($urandom);
      flush = ($urandom_range(0, 63) == 0);
    end
    #1 valid = 0; flush = 0;
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
